uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; consumes the TX line produced by UART_transmitter (8N1, LSB first, start bit 0, stop bit 1).
- Synchronises the asynchronous rx line, detects the start edge, samples each bit at its mid-point, checks the stop bit, and presents the byte through a valid/ack handshake.
- Sits between the serial pin and the byte-consuming logic (FIFO or controller).

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit (clk frequency / baud); legal range 4..65535; must match the transmitter's bit period.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), cycles from the start edge to the start-bit mid-sample.

Ports:
- clk  input  1  system clock; one clock only.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available; held until ack.
- ack  input  1  consumer accepted data; honoured only while valid=1.
- busy  output  1  1 in any state other than IDLE.
- framing_err  output  1  1-cycle pulse when the stop bit samples 0.
- overrun  output  1  1-cycle pulse when a good byte is dropped because valid was still 1.

Behaviour:
- Reset (reset=1 at a clk edge):
  - State <- IDLE; data=0, valid=0, busy=0, framing_err=0, overrun=0.
  - Both synchroniser flops <- 1.
  - Any frame in progress is abandoned, with no flags raised.
- Synchroniser:
  - 2-flop chain rx -> rx_s; all decisions use rx_s (2-cycle input latency).
  - rx_prev holds rx_s delayed by 1 cycle.
- Bit counter:
  - 16-bit down-counter; reloaded on every state entry; a sample is taken when it reaches 0.
  - Bit index: 3-bit, counts 0..7.
- IDLE:
  - When rx_prev=1 and rx_s=0 (falling edge): load counter = HALF_BIT-1 and go to START.
- START:
  - At counter=0, sample rx_s.
  - If 0: load CLKS_PER_BIT-1, bit index=0, go to DATA.
  - If 1: glitch; return to IDLE with no flags and no output change.
- DATA:
  - At counter=0, shift rx_s into the shift register MSB and shift right, so the first bit received lands in data[0].
  - If bit index=7: go to PARITY (when compiled in) or STOP. Otherwise increment the index.
  - Reload the counter with CLKS_PER_BIT-1 on each sample.
- STOP:
  - At counter=0, sample rx_s.
  - If 1 (good frame): go to IDLE and deliver per the handshake rules below.
  - If 0: pulse framing_err for 1 cycle, discard the byte, go to BREAK.
- BREAK:
  - Stay until rx_s=1, then go to IDLE. Prevents a held-low line from retriggering.
- Handshake, evaluated on the good-stop cycle:
  - valid=0: data <- shift register, valid <- 1 next cycle.
  - valid=1 and ack=1 in the same cycle: data <- new byte, valid stays 1, no overrun.
  - valid=1 and ack=0: new byte dropped, data unchanged, overrun pulses for 1 cycle.
  - ack while valid=1 with no new byte: valid <- 0 next cycle.
  - ack while valid=0: ignored.
- Timing:
  - The stop bit is sampled about 9.5 bit periods after the start edge reaches rx_s.
  - valid rises the cycle after that sample.
  - The receiver is back in IDLE at the stop-bit mid-point, so back-to-back frames with a single stop bit are received without loss.
- busy=1 in START, DATA, PARITY, STOP and BREAK.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; the frame is 8E1 (even parity).
  - Adds output port parity_err (1-bit, 1-cycle pulse, reset 0).
  - At the parity mid-sample, parity_err pulses if the XOR of the 8 data bits and the parity bit is 1.
  - The byte is discarded and STOP is still sampled.
  - If the stop bit is also 0, framing_err pulses as well.
- Undefined:
  - No PARITY state and no parity_err port; frame is 8N1.

Test Plan (CLKS_PER_BIT=4, rx driven by an ideal bench model unless noted):
- Reset, then frame 0xA5 -> data=0xA5, valid=1 until ack; valid=0 one cycle after ack; framing_err=0, overrun=0.
- rx low for 1 clk in IDLE -> START samples 1 -> returns to IDLE; valid, framing_err and busy stay 0 after the 2-cycle return.
- Frame 0x3C with stop bit 0, then rx held low for 20 clks -> framing_err one pulse, valid=0, busy=1 (BREAK) until rx returns high, then a normal 0x55 frame is received correctly.
- Frames 0x11, 0x22, 0x33 back-to-back:
  - ack never asserted -> data=0x11, two overrun pulses.
  - Repeat with ack pulsed on the 0x22 good-stop cycle -> data=0x22, one overrun pulse (0x33).
- reset=1 for 1 clk in mid-DATA (after bit 3) -> all outputs 0; the next full frame 0xF0 is received correctly.
- UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> data=0x07, valid=1.
  - 0x07 with parity bit 0 -> parity_err pulse, valid=0.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receive stage.
// Default frame is 8N1 (start 0, eight data bits LSB first, stop 1).
// Define UART_RX_PARITY_EN to receive 8E1 frames. That build adds a PARITY
// state and a parity_err output pulse.
// The byte is handed to the consumer through a valid/ack handshake.
// All outputs are registered.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int          HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_LOAD = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity: the data bits and the parity bit must XOR to 0.
  function automatic logic parity_error(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  // Synchroniser and edge-history registers
  logic       rx_meta_r;
  logic       rx_s_r;
  logic       rx_prev_r;

  // FSM and datapath registers
  state_t     state_r;
  logic [15:0] cnt_r;
  logic [2:0] idx_r;
  logic [7:0] shift_r;
  logic [7:0] data_r;
  logic       valid_r;
  logic       busy_r;
  logic       framing_err_r;
  logic       overrun_r;

  // Next-state values computed by the combinational process
  state_t     next_state_s;
  logic [15:0] next_cnt_s;
  logic [2:0] next_idx_s;
  logic [7:0] next_shift_s;
  logic [7:0] next_data_s;
  logic       next_valid_s;
  logic       next_ferr_s;
  logic       next_ovr_s;
  logic       keep_byte_s;
  logic       cnt_zero_s;

`ifdef UART_RX_PARITY_EN
  logic       parity_bad_r;
  logic       parity_err_r;
  logic       next_parity_bad_s;
  logic       next_perr_s;
`endif

  // Two-flop synchroniser on the asynchronous rx pin, plus a one-cycle
  // delayed copy of the synchronised line for start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
      rx_prev_r <= rx_s_r;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= 16'd0;
      idx_r         <= 3'd0;
      shift_r       <= 8'd0;
      data_r        <= 8'd0;
      valid_r       <= 1'b0;
      busy_r        <= 1'b0;
      framing_err_r <= 1'b0;
      overrun_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_r  <= 1'b0;
      parity_err_r  <= 1'b0;
`endif
    end else begin
      state_r       <= next_state_s;
      cnt_r         <= next_cnt_s;
      idx_r         <= next_idx_s;
      shift_r       <= next_shift_s;
      data_r        <= next_data_s;
      valid_r       <= next_valid_s;
      busy_r        <= (next_state_s != IDLE);
      framing_err_r <= next_ferr_s;
      overrun_r     <= next_ovr_s;
`ifdef UART_RX_PARITY_EN
      parity_bad_r  <= next_parity_bad_s;
      parity_err_r  <= next_perr_s;
`endif
    end
  end

  // Next-state logic: bit timing, data shifting, stop check and handshake.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_idx_s   = idx_r;
    next_shift_s = shift_r;
    next_data_s  = data_r;
    next_ferr_s  = 1'b0;
    next_ovr_s   = 1'b0;
    cnt_zero_s   = (cnt_r == 16'd0);
`ifdef UART_RX_PARITY_EN
    next_parity_bad_s = parity_bad_r;
    next_perr_s       = 1'b0;
    keep_byte_s       = ~parity_bad_r;
`else
    keep_byte_s       = 1'b1;
`endif

    // An ack while a byte is presented retires it. A good stop in the
    // same cycle can override this below.
    if (valid_r && ack) begin
      next_valid_s = 1'b0;
    end else begin
      next_valid_s = valid_r;
    end

    case (state_r)
      IDLE: begin
        if (rx_prev_r && !rx_s_r) begin
          next_state_s = START;
          next_cnt_s   = HALF_LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end

      START: begin
        if (cnt_zero_s) begin
          if (!rx_s_r) begin
            next_state_s = DATA;
            next_cnt_s   = BIT_LOAD;
            next_idx_s   = 3'd0;
          end else begin
            // Line was back high at mid-start: treat the edge as a glitch.
            next_state_s = IDLE;
          end
        end else begin
          next_cnt_s = cnt_r - 16'd1;
        end
      end

      DATA: begin
        if (cnt_zero_s) begin
          next_shift_s = {rx_s_r, shift_r[7:1]};
          next_cnt_s   = BIT_LOAD;
          if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            next_state_s = PARITY;
`else
            next_state_s = STOP;
`endif
          end else begin
            next_idx_s = idx_r + 3'd1;
          end
        end else begin
          next_cnt_s = cnt_r - 16'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_zero_s) begin
          next_parity_bad_s = parity_error(shift_r, rx_s_r);
          next_perr_s       = parity_error(shift_r, rx_s_r);
          next_state_s      = STOP;
          next_cnt_s        = BIT_LOAD;
        end else begin
          next_cnt_s = cnt_r - 16'd1;
        end
      end
`endif

      STOP: begin
        if (cnt_zero_s) begin
          if (rx_s_r) begin
            // Returning to IDLE at the stop mid-point lets a
            // back-to-back frame's start edge be caught.
            next_state_s = IDLE;
            if (keep_byte_s) begin
              if (!valid_r || ack) begin
                next_data_s  = shift_r;
                next_valid_s = 1'b1;
              end else begin
                next_ovr_s = 1'b1;
              end
            end else begin
              next_data_s = data_r;
            end
          end else begin
            next_ferr_s  = 1'b1;
            next_state_s = BREAK;
          end
        end else begin
          next_cnt_s = cnt_r - 16'd1;
        end
      end

      BREAK: begin
        // Wait out a held-low line so it cannot look like a new start edge.
        if (rx_s_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = BREAK;
        end
      end

      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign data        = data_r;
  assign valid       = valid_r;
  assign busy        = busy_r;
  assign framing_err = framing_err_r;
  assign overrun     = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver (CLKS_PER_BIT=4).
// Inputs are driven on the falling clock edge. Outputs are sampled there too.
// Monitors count the single-cycle pulse outputs.
module tb_uart_receiver;

  localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_CLKS = CPB * 11;
`else
  localparam int FRAME_CLKS = CPB * 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       framing_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       bad_parity = 1'b0;
  int         pe_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int base_fe;
  int base_ov;
  int base_busy;
`ifdef UART_RX_PARITY_EN
  int base_pe;
`endif

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .ack         (ack),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Count pulse outputs and busy cycles.
  always @(negedge clk) begin
    if (framing_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (busy === 1'b1) busy_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_parity;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(valid), 32'd1);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ferr", 32'(framing_err), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Frame 0xA5 with handshake
    base_fe = fe_cnt; base_ov = ov_cnt;
    send_frame(8'hA5, 1'b1);
    wait_valid("a5_valid");
    check("a5_data", 32'(data), 32'hA5);
    repeat (3) @(negedge clk);
    check("a5_valid_held", 32'(valid), 32'd1);
    ack_pulse();
    check("a5_valid_after_ack", 32'(valid), 32'd0);
    check("a5_ferr", 32'(fe_cnt - base_fe), 32'd0);
    check("a5_ovr", 32'(ov_cnt - base_ov), 32'd0);

    // One-cycle glitch
    base_fe = fe_cnt; base_busy = busy_cnt;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_seen", 32'(busy_cnt - base_busy > 0), 32'd1);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_ferr", 32'(fe_cnt - base_fe), 32'd0);

    // Framing error, held break, then a good frame
    base_fe = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("break_ferr", 32'(fe_cnt - base_fe), 32'd1);
    check("break_valid", 32'(valid), 32'd0);
    check("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break_released", 32'(busy), 32'd0);
    send_frame(8'h55, 1'b1);
    wait_valid("after_break_valid");
    check("after_break_data", 32'(data), 32'h55);
    ack_pulse();

    // Back-to-back frames without ack: the first byte is kept
    base_ov = ov_cnt; base_fe = fe_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    repeat (8) @(negedge clk);
    check("b2b_data", 32'(data), 32'h11);
    check("b2b_valid", 32'(valid), 32'd1);
    check("b2b_ovr", 32'(ov_cnt - base_ov), 32'd2);
    check("b2b_ferr", 32'(fe_cnt - base_fe), 32'd0);
    ack_pulse();
    check("b2b_cleared", 32'(valid), 32'd0);

    // Back-to-back with ack on the second frame's good-stop cycle
    base_ov = ov_cnt;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
      end
      begin
        repeat (2 * FRAME_CLKS) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    check("b2b_ack_data", 32'(data), 32'h22);
    check("b2b_ack_valid", 32'(valid), 32'd1);
    check("b2b_ack_ovr", 32'(ov_cnt - base_ov), 32'd1);
    ack_pulse();

    // Reset in mid-DATA, then a clean frame
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (24) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_data", 32'(data), 32'h00);
        check("mid_reset_valid", 32'(valid), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
      end
    join
    base_fe = fe_cnt;
    repeat (4) @(negedge clk);
    send_frame(8'hF0, 1'b1);
    wait_valid("f0_valid");
    check("f0_data", 32'(data), 32'hF0);
    check("f0_ferr", 32'(fe_cnt - base_fe), 32'd0);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so its parity bit is 1
    base_pe = pe_cnt;
    bad_parity = 1'b0;
    send_frame(8'h07, 1'b1);
    wait_valid("par_ok_valid");
    check("par_ok_data", 32'(data), 32'h07);
    check("par_ok_perr", 32'(pe_cnt - base_pe), 32'd0);
    ack_pulse();
    bad_parity = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (8) @(negedge clk);
    check("par_bad_perr", 32'(pe_cnt - base_pe), 32'd1);
    check("par_bad_valid", 32'(valid), 32'd0);
    bad_parity = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
